// File: rtl/sc_tick_meter_pkg.sv
// rtl/sc_tick_meter_pkg.sv - shared types and constants for the tick meter
// Purpose: FSM state encoding, speed-zone width and zone codes used by the
//          tick meter top level and its bench.
// Ports:   none (package)
package sc_tick_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_STALL   = 2'd2
  } state_t;

  localparam int ZONE_W = 3;

  localparam logic [ZONE_W-1:0] ZONE_STOP = 3'd0;
  localparam logic [ZONE_W-1:0] ZONE_1    = 3'd1;
  localparam logic [ZONE_W-1:0] ZONE_2    = 3'd2;
  localparam logic [ZONE_W-1:0] ZONE_3    = 3'd3;
  localparam logic [ZONE_W-1:0] ZONE_4    = 3'd4;

endpackage

// File: rtl/sc_tick_edge.sv
// rtl/sc_tick_edge.sv - rising-edge detector for the tick stream
// Purpose: registers the previous tick level so that a high level of any
//          length produces a single one-cycle event.
// Ports:   i_clk    - clock, rising edge
//          i_rst_n  - asynchronous active-low reset
//          i_tick   - synchronous tick level
//          o_edge   - high in the cycle where tick is high and was low before
module sc_tick_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tick,
  output logic o_edge
);

  logic r_tick_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tick_prev <= 1'b0;
    end else begin
      r_tick_prev <= i_tick;
    end
  end

  assign o_edge = i_tick & ~r_tick_prev;

endmodule

// File: rtl/sc_tick_meter.sv
// rtl/sc_tick_meter.sv - tick period meter with speed-zone classification
// Purpose: measures the number of clocks between successive tick rising edges,
//          classifies the period into speed zones 0..4, and presents the
//          result with a valid/ack handshake, overrun and timeout flags.
// Ports:   SC_TickMETER_CLOCK_50        - clock, rising edge
//          SC_TickMETER_RESET_InLow     - asynchronous active-low reset
//          SC_TickMETER_ENABLE_InHigh   - measurement enable
//          SC_TickMETER_TICK_InHigh     - tick level from the speed timer
//          SC_TickMETER_ACK_InHigh      - consumer acknowledge
//          SC_TickMETER_period_OutBUS   - last measured period in clocks
//          SC_TickMETER_zone_OutBUS     - speed zone (0 stopped, 4 fastest)
//          SC_TickMETER_VALID_OutHigh   - result pending
//          SC_TickMETER_OVERRUN_OutHigh - unacknowledged result overwritten
//          SC_TickMETER_TIMEOUT_OutHigh - no edge within MAX_PERIOD clocks
module sc_tick_meter
  import sc_tick_meter_pkg::*;
#(
  parameter int PERIOD_WIDTH = 26,
  parameter int TH1          = 10_000_000,
  parameter int TH2          = 14_000_000,
  parameter int TH3          = 17_500_000,
  parameter int TH4          = 25_000_000,
  parameter int MAX_PERIOD   = 50_000_000
) (
  input  logic                    SC_TickMETER_CLOCK_50,
  input  logic                    SC_TickMETER_RESET_InLow,
  input  logic                    SC_TickMETER_ENABLE_InHigh,
  input  logic                    SC_TickMETER_TICK_InHigh,
  input  logic                    SC_TickMETER_ACK_InHigh,
  output logic [PERIOD_WIDTH-1:0] SC_TickMETER_period_OutBUS,
  output logic [ZONE_W-1:0]       SC_TickMETER_zone_OutBUS,
  output logic                    SC_TickMETER_VALID_OutHigh,
  output logic                    SC_TickMETER_OVERRUN_OutHigh,
  output logic                    SC_TickMETER_TIMEOUT_OutHigh
);

  localparam logic [PERIOD_WIDTH-1:0] L_TH1  = PERIOD_WIDTH'(TH1);
  localparam logic [PERIOD_WIDTH-1:0] L_TH2  = PERIOD_WIDTH'(TH2);
  localparam logic [PERIOD_WIDTH-1:0] L_TH3  = PERIOD_WIDTH'(TH3);
  localparam logic [PERIOD_WIDTH-1:0] L_TH4  = PERIOD_WIDTH'(TH4);
  localparam logic [PERIOD_WIDTH-1:0] L_MAX  = PERIOD_WIDTH'(MAX_PERIOD);
  localparam logic [PERIOD_WIDTH-1:0] L_ONE  = PERIOD_WIDTH'(1);
  localparam logic [PERIOD_WIDTH-1:0] L_ZERO = '0;

  // Equality belongs to the faster zone.
  function automatic logic [ZONE_W-1:0] classify(input logic [PERIOD_WIDTH-1:0] c);
    if (c <= L_TH1)      return ZONE_4;
    else if (c <= L_TH2) return ZONE_3;
    else if (c <= L_TH3) return ZONE_2;
    else if (c <= L_TH4) return ZONE_1;
    else                 return ZONE_STOP;
  endfunction

  logic w_edge;

  sc_tick_edge u_edge (
    .i_clk   (SC_TickMETER_CLOCK_50),
    .i_rst_n (SC_TickMETER_RESET_InLow),
    .i_tick  (SC_TickMETER_TICK_InHigh),
    .o_edge  (w_edge)
  );

  state_t                  r_state,   w_state;
  logic [PERIOD_WIDTH-1:0] r_count,   w_count;
  logic [PERIOD_WIDTH-1:0] r_period,  w_period;
  logic [ZONE_W-1:0]       r_zone,    w_zone;
  logic                    r_valid,   w_valid;
  logic                    r_overrun, w_overrun;
  logic                    r_timeout, w_timeout;
  logic                    w_capture;

  always_ff @(posedge SC_TickMETER_CLOCK_50 or negedge SC_TickMETER_RESET_InLow) begin
    if (!SC_TickMETER_RESET_InLow) begin
      r_state   <= ST_IDLE;
      r_count   <= L_ZERO;
      r_period  <= L_ZERO;
      r_zone    <= ZONE_STOP;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_count   <= w_count;
      r_period  <= w_period;
      r_zone    <= w_zone;
      r_valid   <= w_valid;
      r_overrun <= w_overrun;
      r_timeout <= w_timeout;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_count   = r_count;
    w_period  = r_period;
    w_zone    = r_zone;
    w_valid   = r_valid;
    w_overrun = r_overrun;
    w_timeout = r_timeout;
    w_capture = 1'b0;

    if (!SC_TickMETER_ENABLE_InHigh) begin
      // Disabling abandons the measurement but keeps the last result visible.
      w_state   = ST_IDLE;
      w_count   = L_ZERO;
      w_valid   = 1'b0;
      w_timeout = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_edge) begin
            w_count = L_ONE;
            w_state = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (w_edge) begin
            w_capture = 1'b1;
            w_count   = L_ONE;
          end else if (r_count >= L_MAX) begin
            // Count is held at MAX_PERIOD so it can never wrap.
            w_state   = ST_STALL;
            w_timeout = 1'b1;
            w_zone    = ZONE_STOP;
          end else begin
            w_count = r_count + L_ONE;
          end
        end
        ST_STALL: begin
          if (w_edge) begin
            w_timeout = 1'b0;
            w_count   = L_ONE;
            w_state   = ST_MEASURE;
          end
        end
        default: begin
          w_state = ST_IDLE;
          w_count = L_ZERO;
        end
      endcase

      // A capture takes priority over an ack in the same cycle; only a
      // capture against a pending, unacknowledged result is an overrun.
      if (w_capture) begin
        w_period = r_count;
        w_zone   = classify(r_count);
        w_valid  = 1'b1;
        if (r_valid && !SC_TickMETER_ACK_InHigh) begin
          w_overrun = 1'b1;
        end
      end else if (SC_TickMETER_ACK_InHigh && r_valid) begin
        w_valid   = 1'b0;
        w_overrun = 1'b0;
      end
    end
  end

  assign SC_TickMETER_period_OutBUS   = r_period;
  assign SC_TickMETER_zone_OutBUS     = r_zone;
  assign SC_TickMETER_VALID_OutHigh   = r_valid;
  assign SC_TickMETER_OVERRUN_OutHigh = r_overrun;
  assign SC_TickMETER_TIMEOUT_OutHigh = r_timeout;

endmodule

// File: doc/sc_tick_meter.md
SC_TICK_METER -- requirements
Module: sc_tick_meter

Interface
REQ-001 The block SHALL have parameter PERIOD_WIDTH, default 26, giving the width of the period counter and result.
REQ-002 The block SHALL have parameter TH1, default 10_000_000, giving the zone-4 upper bound in clocks (0.20 s at 50 MHz).
REQ-003 The block SHALL have parameter TH2, default 14_000_000, giving the zone-3 upper bound in clocks.
REQ-004 The block SHALL have parameter TH3, default 17_500_000, giving the zone-2 upper bound in clocks.
REQ-005 The block SHALL have parameter TH4, default 25_000_000, giving the zone-1 upper bound in clocks.
REQ-006 The block SHALL have parameter MAX_PERIOD, default 50_000_000, giving the timeout count; the constraint is TH1<TH2<TH3<TH4<MAX_PERIOD<2^PERIOD_WIDTH.
REQ-007 The block SHALL have port SC_TickMETER_CLOCK_50, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 The block SHALL have port SC_TickMETER_RESET_InLow, input, 1 bit: reset, asynchronous and active-low.
REQ-009 The block SHALL have port SC_TickMETER_ENABLE_InHigh, input, 1 bit: measurement enable.
REQ-010 The block SHALL have port SC_TickMETER_TICK_InHigh, input, 1 bit: synchronous tick stream from the speed timer; a level of any length counts as one event.
REQ-011 The block SHALL have port SC_TickMETER_ACK_InHigh, input, 1 bit: consumer acknowledge of the current result.
REQ-012 The block SHALL have port SC_TickMETER_period_OutBUS, output, PERIOD_WIDTH bits: last measured period in clocks.
REQ-013 The block SHALL have port SC_TickMETER_zone_OutBUS, output, 3 bits: speed zone 0..4 (0 = stopped, 4 = fastest).
REQ-014 The block SHALL have port SC_TickMETER_VALID_OutHigh, output, 1 bit: a result is pending.
REQ-015 The block SHALL have port SC_TickMETER_OVERRUN_OutHigh, output, 1 bit: sticky flag for an unacknowledged result that was overwritten.
REQ-016 The block SHALL have port SC_TickMETER_TIMEOUT_OutHigh, output, 1 bit: no tick edge arrived within MAX_PERIOD.

Function
REQ-017 The block SHALL detect an event as a rising edge of TICK (TICK high while the registered previous TICK was low).
REQ-018 The block SHALL implement three states: IDLE, MEASURE and STALL.
REQ-019 In IDLE with ENABLE high, an edge SHALL load count<=1 and move to MEASURE without publishing a result.
REQ-020 In MEASURE, the count SHALL increment by 1 every cycle with no edge, so that a capture holds the number of clocks between the two edges.
REQ-021 In MEASURE, an edge SHALL load period<=count and zone<=classify(count), set VALID, reload count<=1 and stay in MEASURE.
REQ-022 In MEASURE, when count reaches MAX_PERIOD without an edge, the block SHALL enter STALL, set TIMEOUT=1 and zone=0, hold the count and leave period unchanged.
REQ-023 In STALL, an edge SHALL clear TIMEOUT, load count<=1 and enter MEASURE without publishing a result.
REQ-024 The classification SHALL be: count<=TH1 gives 4, <=TH2 gives 3, <=TH3 gives 2, <=TH4 gives 1, otherwise 0; equality belongs to the faster zone.
REQ-025 Latency SHALL be one cycle: for an edge in cycle N, period, zone and VALID are visible in cycle N+1.
REQ-026 VALID SHALL stay high until a cycle with ACK high, and clear in the following cycle.
REQ-027 If a capture and ACK occur in the same cycle, the new result SHALL win, VALID SHALL stay 1 and OVERRUN SHALL not be set.
REQ-028 If a capture occurs while VALID=1 and ACK=0, the block SHALL overwrite the result and set OVERRUN=1.
REQ-029 OVERRUN SHALL clear only when ACK is high and no capture occurs in that cycle.
REQ-030 ENABLE low SHALL synchronously force IDLE, count=0, VALID=0 and TIMEOUT=0, while holding period, zone and OVERRUN.
REQ-031 The counter SHALL never wrap; MAX_PERIOD bounds it.
REQ-032 ACK while VALID=0 SHALL be ignored.

Reset
REQ-033 Reset low SHALL immediately set state=IDLE, count=0, previous TICK=0, period=0, zone=0, VALID=0, OVERRUN=0 and TIMEOUT=0.
REQ-034 Reset asserted mid-measurement SHALL discard the partial count, and the first edge after release SHALL only arm the block.

Structure
REQ-035 A shared package SHALL hold the state encoding (IDLE/MEASURE/STALL), the zone constants ZONE_STOP..ZONE_4 and the 3-bit zone width.
REQ-036 One sub-module, sc_tick_edge, SHALL hold the TICK history register and rising-edge output, and use the same clock and reset.
REQ-037 The top level SHALL contain the FSM, the counter, the classifier and the result/handshake registers.

Verification
The bench SHALL use TH1=10, TH2=14, TH3=17, TH4=25 and MAX_PERIOD=50.
REQ-038 The bench SHALL check edges at cycles 100 and 112 with no ACK -> at cycle 113 period=12, zone=3, VALID=1, OVERRUN=0.
REQ-039 The bench SHALL check edges 10 cycles apart, then 17 apart, with no ACK -> results zone=4 then zone=2, OVERRUN=1 after the second capture.
REQ-040 The bench SHALL check ACK in the same cycle as a capture of period 25 -> VALID stays 1, OVERRUN=0, zone=1.
REQ-041 The bench SHALL check one edge followed by 50 idle cycles -> TIMEOUT=1 and zone=0 with period unchanged; the next edge clears TIMEOUT with VALID not asserted.
REQ-042 The bench SHALL check TICK held high for 30 cycles -> a single event only, with no captures during the high level.
REQ-043 The bench SHALL check reset pulsed low at count=7 -> all outputs 0 immediately; after release, the first edge arms the block and the second publishes a result.
